// File: rtl/fconv_pkg.sv
// Shared definitions for the FloPoCo converter family: exception encodings,
// default field widths and the packed FloPoCo word layout.
package fconv_pkg;

  localparam int WE_DEF = 6;
  localparam int WF_DEF = 6;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef struct packed {
    logic [1:0]        exc;
    logic              sign;
    logic [WE_DEF-1:0] exp;
    logic [WF_DEF-1:0] frac;
  } flopoco_word_t;

endpackage

// File: rtl/fconv_decode.sv
// Combinational classify/field-build from an IEEE word to a FloPoCo word.
// Subnormals with frac MSB set map exactly when FCONV_SUBNORM_EN is defined.
module fconv_decode import fconv_pkg::*; #(
  parameter int WE = WE_DEF,
  parameter int WF = WF_DEF
) (
  input  logic [WE+WF:0]   ieee,
  output logic [WE+WF+2:0] fp,
  output logic             nan,
  output logic             uflow
);

  logic          sign_s;
  logic [WE-1:0] exp_s;
  logic [WF-1:0] frac_s;

  assign sign_s = ieee[WE+WF];
  assign exp_s  = ieee[WE+WF-1:WF];
  assign frac_s = ieee[WF-1:0];

  // Classify the input and build the FloPoCo fields plus per-word flags.
  always_comb begin
    fp    = {EXC_ZERO, sign_s, {(WE+WF){1'b0}}};
    nan   = 1'b0;
    uflow = 1'b0;
    if (exp_s == {WE{1'b0}}) begin
      if (frac_s == {WF{1'b0}}) begin
        fp = {EXC_ZERO, sign_s, {(WE+WF){1'b0}}};
      end else begin
`ifdef FCONV_SUBNORM_EN
        // 0.1xxxxx * 2^-30 is exactly 1.xxxxx0 * 2^-31, i.e. biased exponent 0
        if (frac_s[WF-1]) begin
          fp = {EXC_NORM, sign_s, {WE{1'b0}}, frac_s[WF-2:0], 1'b0};
        end else begin
          uflow = 1'b1;
        end
`else
        uflow = 1'b1;
`endif
      end
    end else if (exp_s == {WE{1'b1}}) begin
      if (frac_s == {WF{1'b0}}) begin
        fp = {EXC_INF, sign_s, {(WE+WF){1'b0}}};
      end else begin
        fp  = {EXC_NAN, 1'b0, {(WE+WF){1'b0}}};
        nan = 1'b1;
      end
    end else begin
      fp = {EXC_NORM, sign_s, exp_s, frac_s};
    end
  end

endmodule

// File: rtl/fconv_ieee2fp.sv
// Two-stage valid/ready IEEE -> FloPoCo converter with NaN/underflow flags and
// a saturating flush counter. Optional exact subnormal mapping: FCONV_SUBNORM_EN.
module fconv_ieee2fp import fconv_pkg::*; #(
  parameter int WE    = WE_DEF,
  parameter int WF    = WF_DEF,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WE+WF:0]     in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WE+WF+2:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_nan,
  output logic               out_uflow,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [WE+WF+2:0] dec_fp_s;
  logic             dec_nan_s;
  logic             dec_uflow_s;
  logic             s1_adv_s;
  logic             in_fire_s;

  logic             s1_valid_r;
  logic [WE+WF+2:0] s1_data_r;
  logic             s1_nan_r;
  logic             s1_uflow_r;

  fconv_decode #(.WE(WE), .WF(WF)) u_decode (
    .ieee  (in_data),
    .fp    (dec_fp_s),
    .nan   (dec_nan_s),
    .uflow (dec_uflow_s)
  );

  assign s1_adv_s  = !out_valid || out_ready;
  assign in_ready  = !s1_valid_r || s1_adv_s;
  assign in_fire_s = in_valid && in_ready;

  // Stage 1: capture decoded word whenever the stage is free or draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(WE+WF+3){1'b0}};
      s1_nan_r   <= 1'b0;
      s1_uflow_r <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r  <= dec_fp_s;
        s1_nan_r   <= dec_nan_s;
        s1_uflow_r <= dec_uflow_s;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {(WE+WF+3){1'b0}};
      out_nan   <= 1'b0;
      out_uflow <= 1'b0;
    end else if (s1_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data  <= s1_data_r;
        out_nan   <= s1_nan_r;
        out_uflow <= s1_uflow_r;
      end
    end
  end

  // Flush counter: counts accepted flushed words, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= {CNT_W{1'b0}};
    end else if (in_fire_s && dec_uflow_s && (flush_cnt != {CNT_W{1'b1}})) begin
      flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fconv_ieee2fp.sv
// Scoreboard bench for fconv_ieee2fp: directed test-plan words, backpressure,
// reset mid-stream, counter saturation and randomized traffic vs. a value model.
module tb_fconv_ieee2fp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] in_data = 13'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_nan;
  logic        out_uflow;
  logic [7:0]  flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  bit rand_rdy = 1'b0;
  logic [16:0] sb_q[$];   // {nan, uflow, data[14:0]}

  fconv_ieee2fp dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_nan(out_nan), .out_uflow(out_uflow),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Value-level reference: what real number does the IEEE word denote, and
  // how is it expressed as (exc, sign, biased exp, frac) in FloPoCo.
  function automatic logic [16:0] ref_conv(input logic [12:0] w);
    int s, e, f, exc, oe, of_, nan, uf;
    s = int'(w[12]); e = int'(w[11:6]); f = int'(w[5:0]);
    nan = 0; uf = 0; exc = 0; oe = 0; of_ = 0;
    if (e == 63) begin
      if (f == 0) exc = 2;
      else begin exc = 3; s = 0; nan = 1; end
    end else if (e > 0) begin
      exc = 1; oe = e; of_ = f;
    end else if (f != 0) begin
`ifdef FCONV_SUBNORM_EN
      if (f >= 32) begin exc = 1; oe = 0; of_ = (f - 32) * 2; end
      else uf = 1;
`else
      uf = 1;
`endif
    end
    return 17'(nan * 65536 + uf * 32768 + exc * 8192 + s * 4096 + oe * 64 + of_);
  endfunction

  // Scoreboard monitor: checks every output transfer and the flush counter.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      check("flush_cnt", int'(flush_cnt), model_cnt);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [16:0] e;
          e = sb_q.pop_front();
          check("out_data", int'(out_data), int'(e[14:0]));
          check("out_nan", int'(out_nan), int'(e[16]));
          check("out_uflow", int'(out_uflow), int'(e[15]));
        end
      end
    end
  end

  // Randomized consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Offer one word (caller is at posedge+1) and wait for its acceptance.
  task automatic send(input logic [12:0] w, input logic [16:0] exp);
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    sb_q.push_back(exp);
    if (exp[15] && model_cnt < 255) model_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [12:0] w;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_flags", int'({out_nan, out_uflow}), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Directed test-plan words with literal expectations.
    send(13'h07C0, {2'b00, 15'h27C0});
    send(13'h1000, {2'b00, 15'h1000});
    send(13'h0FC0, {2'b00, 15'h4000});
    send(13'h1FC0, {2'b00, 15'h5000});
    send(13'h1FC5, {2'b10, 15'h6000});
`ifdef FCONV_SUBNORM_EN
    send(13'h0020, {2'b00, 15'h2000});
`else
    send(13'h0020, {2'b01, 15'h0000});
`endif
    send(13'h0001, {2'b01, 15'h0000});
    send(13'h1001, {2'b01, 15'h1000});
    drain();

    // Backpressure: two words fill the pipe, the third is refused.
    out_ready = 1'b0;
    in_data = 13'h07C0; in_valid = 1'b1;
    @(negedge clk); check("bp_rdy_a", int'(in_ready), 1);
    @(posedge clk); #1 sb_q.push_back({2'b00, 15'h27C0});
    in_data = 13'h0FC0;
    @(negedge clk); check("bp_rdy_b", int'(in_ready), 1);
    @(posedge clk); #1 sb_q.push_back({2'b00, 15'h4000});
    in_data = 13'h0A15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_rdy", int'(in_ready), 0);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_data", int'(out_data), 15'h27C0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check("bp_release_rdy", int'(in_ready), 1);
    @(posedge clk); #1 sb_q.push_back({2'b00, 15'h2A15});
    in_valid = 1'b0;
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(13'h07C0, {2'b00, 15'h27C0});
    send(13'h0001, {2'b01, 15'h0000});
    @(negedge clk); check("pre_rst_full", int'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_flush_cnt", int'(flush_cnt), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(13'h0C41, {2'b00, 15'h2C41});
    drain();

    // Randomized traffic with random consumer stalls and gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      w = 13'($urandom);
      case ($urandom_range(0, 5))
        0: w[11:6] = 6'd0;
        1: w[11:6] = 6'h3F;
        default: ;
      endcase
      send(w, ref_conv(w));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    #2 out_ready = 1'b1;
    drain();

    // Saturation: 300 flushed words pin the counter at 255.
    for (int i = 0; i < 300; i++) send(13'h0001 + 13'(i % 31), {2'b01, 15'h0000});
    drain();
    @(negedge clk);
    check("flush_sat", int'(flush_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
